// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared instruction-cache geometry, address/frame structs and FSM state type
package cpu_types_pkg;

  // 16 direct-mapped frames, one 32-bit word per block
  localparam int ITAG_W  = 26;
  localparam int IIDX_W  = 4;
  localparam int IBYT_W  = 2;
  localparam int IFRAMES = 1 << IIDX_W;

  // Instruction address view: {tag, index, byte offset}
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - 16-frame direct-mapped read-only instruction cache with single-request refill FSM
//
// Ports:
//   CLK               sole clock, rising edge
//   nRST              asynchronous active-low reset
//   i_dcif_imemREN    datapath instruction read request
//   i_dcif_imemaddr   instruction address (bits 1:0 ignored)
//   o_dcif_ihit       requested word valid this cycle
//   o_dcif_imemload   instruction word (0 when not hitting)
//   o_cif_iREN        memory read request (high only while refilling)
//   o_cif_iaddr       memory read address (latched miss address, else 0)
//   i_cif_iwait       memory busy; data valid when low
//   i_cif_iload       memory read data
module icache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_dcif_imemREN,
  input  logic [31:0] i_dcif_imemaddr,
  output logic        o_dcif_ihit,
  output logic [31:0] o_dcif_imemload,
  output logic        o_cif_iREN,
  output logic [31:0] o_cif_iaddr,
  input  logic        i_cif_iwait,
  input  logic [31:0] i_cif_iload
);

  icache_state_t     r_state;
  icachef_t          r_miss;
  logic [IFRAMES-1:0] r_valid;
  logic [ITAG_W-1:0] r_tag  [IFRAMES];
  logic [31:0]       r_data [IFRAMES];

  icachef_t      w_req;
  icache_frame_t w_frame;
  logic          w_hit;
  logic          w_fill;

  // Byte offset is cleared up front so the latched miss address is word aligned
  assign w_req   = icachef_t'(i_dcif_imemaddr & ~32'h3);
  assign w_frame = '{valid: r_valid[w_req.idx], tag: r_tag[w_req.idx], data: r_data[w_req.idx]};
  assign w_hit   = i_dcif_imemREN & w_frame.valid & (w_frame.tag == w_req.tag);

  // The memory word returns on the cycle iwait drops while refilling
  assign w_fill  = (r_state == FETCH) & ~i_cif_iwait;

  assign o_dcif_ihit     = w_hit & (r_state == IDLE);
  assign o_dcif_imemload = w_hit ? w_frame.data : 32'h0;
  assign o_cif_iREN      = (r_state == FETCH);
  assign o_cif_iaddr     = (r_state == FETCH) ? r_miss : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_miss  <= '0;
      r_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_dcif_imemREN && !w_hit) begin
            r_state <= FETCH;
            r_miss  <= w_req;
          end
        end
        FETCH: begin
          // Request changes during a refill are ignored; the fill always completes
          if (!i_cif_iwait) begin
            r_state              <= IDLE;
            r_valid[r_miss.idx]  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits guard it. A reset forces
  // r_state to IDLE asynchronously, so an abandoned refill never writes here.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[r_miss.idx]  <= r_miss.tag;
      r_data[r_miss.idx] <= i_cif_iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized scoreboard bench for icache against an address-keyed cache model
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;

  icache dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .i_dcif_imemREN  (imemREN),
    .i_dcif_imemaddr (imemaddr),
    .o_dcif_ihit     (ihit),
    .o_dcif_imemload (imemload),
    .o_cif_iREN      (iREN),
    .o_cif_iaddr     (iaddr),
    .i_cif_iwait     (iwait),
    .i_cif_iload     (iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          ihit;
    logic [31:0] load;
    bit          iren;
    logic [31:0] iaddr;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   done     = 0;

  // Model: each cache line remembers the full word address it holds
  int unsigned m_line [int];
  logic [31:0] m_word [int];
  bit          m_fetch = 0;
  logic [31:0] m_addr  = 32'h0;
  int          m_wait  = 0;
  int          next_wait = 2;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0)  return 32'h2001000A;
    if (a == 32'h40) return 32'h8C220004;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic bit model_hit(input bit ren, input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    return ren && m_line.exists(line_of(w)) && (m_line[line_of(w)] == w);
  endfunction

  function automatic void model_reset();
    m_line.delete();
    m_word.delete();
    m_fetch = 0;
    m_addr  = 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, queue the expected
  // outputs for this cycle, then advance the model across the next edge.
  task automatic step(input bit rst_n, input bit ren, input logic [31:0] a, input string tag);
    exp_t e;
    nRST     = rst_n;
    imemREN  = ren;
    imemaddr = a;
    if (!rst_n) model_reset();
    iwait = m_fetch ? (m_wait > 0) : 1'($urandom_range(0, 1));
    iload = m_fetch ? memword(m_addr) : $urandom;
    e.ihit  = !m_fetch && model_hit(ren, a);
    e.load  = model_hit(ren, a) ? m_word[line_of(a & ~32'h3)] : 32'h0;
    e.iren  = m_fetch;
    e.iaddr = m_fetch ? m_addr : 32'h0;
    e.tag   = tag;
    exp_q.push_back(e);
    @(posedge CLK);
    if (!rst_n) begin
      model_reset();
    end else if (m_fetch) begin
      if (!iwait) begin
        m_line[line_of(m_addr)] = m_addr;
        m_word[line_of(m_addr)] = iload;
        m_fetch = 0;
      end else begin
        m_wait--;
      end
    end else if (ren && !model_hit(ren, a)) begin
      m_fetch = 1;
      m_addr  = a & ~32'h3;
      m_wait  = next_wait;
    end
    #1;
  endtask

  // Monitor: compares whatever the DUT presents each cycle against the queue head
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".ihit"},     32'(ihit),  32'(e.ihit));
        check({e.tag, ".imemload"}, imemload,   e.load);
        check({e.tag, ".iREN"},     32'(iREN),  32'(e.iren));
        check({e.tag, ".iaddr"},    iaddr,      e.iaddr);
      end
    end
  end

  initial begin
    @(posedge CLK); #1;
    step(0, 0, 32'h0, "reset");
    step(0, 1, 32'h0, "reset_req");

    // Cold miss with two wait cycles
    next_wait = 2;
    for (int i = 0; i < 6; i++) step(1, 1, 32'h0, "cold");

    // Conflict miss on index 0, then the original address misses again
    for (int i = 0; i < 6; i++) step(1, 1, 32'h40, "conflict");
    for (int i = 0; i < 6; i++) step(1, 1, 32'h3, "reconflict");

    // Address change during a refill
    step(1, 1, 32'h8, "chg_miss");
    for (int i = 0; i < 7; i++) step(1, 1, 32'hC, "chg_new");
    step(1, 1, 32'h8, "chg_old");

    // Reset asserted mid-refill
    next_wait = 3;
    step(1, 1, 32'h10, "rstmid_miss");
    step(1, 1, 32'h10, "rstmid_fetch");
    step(0, 1, 32'h10, "rstmid_low");
    step(0, 1, 32'h10, "rstmid_low2");
    for (int i = 0; i < 7; i++) step(1, 1, 32'h10, "rstmid_after");

    // Idle: no request, including a cached address
    step(1, 0, 32'h40, "idle_cached");
    step(1, 0, 32'h0, "idle_other");
    step(1, 0, 32'hFFFF_FFFC, "idle_any");
    step(1, 1, 32'h40, "idle_then_req");

    // Randomized traffic over a small tag pool to force conflicts
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      next_wait = $urandom_range(0, 3);
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      if (($urandom % 5) == 0) a = a | 32'h8000_0000;
      step(($urandom % 150) != 0, ($urandom % 5) != 0, a, "rand");
    end

    step(1, 0, 32'h0, "drain");
    @(negedge CLK);
    @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    done = 1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
